// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bundles for mem_access_unit.
// Both interfaces live in this file; the unit takes req as slave and mem as master.
interface mau_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface mau_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic [DATA_W-1:0] mem_readData;
  logic              mem_memWrite;
  logic              mem_memRead;

  modport master (
    output mem_address, mem_writeData, mem_memWrite, mem_memRead,
    input  mem_readData
  );
  modport slave (
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
    output mem_readData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine for a big-endian, word-write-only data memory; sub-word stores are read-modify-write.
// Optional macro MAU_ALIGN_CHECK_EN rejects misaligned half/word requests with resp_err.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mau_req_if.slave   req,
  mau_mem_if.master  mem,
  output logic [2:0] o_dbg_state
);

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_req_err;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_merge;

`ifdef MAU_ALIGN_CHECK_EN
  assign w_req_err = (req.req_size == 2'b11) ||
                     ((req.req_size == 2'b01) && req.req_addr[0]) ||
                     ((req.req_size == 2'b10) && (req.req_addr[1:0] != 2'b00));
`else
  assign w_req_err = (req.req_size == 2'b11);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req.req_valid) begin
          if (w_req_err)                  w_next = S_RESP;
          else if (!req.req_write)        w_next = S_LOAD;
          else if (req.req_size == 2'b10) w_next = S_ST_WR;
          else                            w_next = S_ST_RD;
        end
      end
      S_LOAD:  w_next = S_RESP;
      S_ST_RD: w_next = S_ST_WR;
      S_ST_WR: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte lane is [31:24], halfword lane is [31:16]; the sign bit is always bit 31.
  always_comb begin
    w_load_ext = mem.mem_readData;
    case (r_size)
      2'b00: w_load_ext = r_unsigned ? {24'd0, mem.mem_readData[31:24]}
                                     : {{24{mem.mem_readData[31]}}, mem.mem_readData[31:24]};
      2'b01: w_load_ext = r_unsigned ? {16'd0, mem.mem_readData[31:16]}
                                     : {{16{mem.mem_readData[31]}}, mem.mem_readData[31:16]};
      default: ;
    endcase
  end

  always_comb begin
    w_merge = r_wdata;
    case (r_size)
      2'b00:   w_merge = {r_wdata[7:0], r_old[23:0]};
      2'b01:   w_merge = {r_wdata[15:0], r_old[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_old      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.req_valid) begin
            r_size     <= req.req_size;
            r_unsigned <= req.req_unsigned;
            r_addr     <= req.req_addr;
            r_wdata    <= req.req_wdata;
            r_err      <= w_req_err;
            r_rdata    <= '0;
          end
        end
        S_LOAD:  r_rdata <= w_load_ext;
        S_ST_RD: r_old   <= mem.mem_readData;
        default: ;
      endcase
    end
  end

  // The write strobe is gated by rst so a reset landing on ST_WR commits nothing.
  always_comb begin
    req.req_ready     = (r_state == S_IDLE);
    req.resp_valid    = (r_state == S_RESP);
    req.resp_rdata    = (r_state == S_RESP) ? r_rdata : '0;
    req.resp_err      = (r_state == S_RESP) ? r_err : 1'b0;
    mem.mem_address   = (r_state == S_IDLE) ? '0 : r_addr;
    mem.mem_memRead   = (r_state == S_LOAD) || (r_state == S_ST_RD);
    mem.mem_memWrite  = (r_state == S_ST_WR) && !rst;
    mem.mem_writeData = (r_state == S_ST_WR) ? w_merge : '0;
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array memory, directed vector table,
// reset-during-write sequence and randomized requests against a byte-level reference model.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  logic [2:0] idle_dbg;

  always #5 clk = ~clk;

  mau_req_if req_if ();
  mau_mem_if mem_if ();

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req_if.slave),
    .mem         (mem_if.master),
    .o_dbg_state (dbg_state)
  );

  // Memory seen by the DUT, and the reference model's view of the same bytes.
  logic [7:0] mem     [0:1023] = '{256: 8'h80, 257: 8'h12, 258: 8'h34, 259: 8'h56, default: 8'h00};
  logic [7:0] ref_mem [0:1023] = '{256: 8'h80, 257: 8'h12, 258: 8'h34, 259: 8'h56, default: 8'h00};
  logic [9:0] rd_a;

  always_comb begin
    rd_a = mem_if.mem_address[9:0];
    mem_if.mem_readData = {mem[rd_a], mem[rd_a + 10'd1], mem[rd_a + 10'd2], mem[rd_a + 10'd3]};
  end

  always @(posedge clk) begin
    if (mem_if.mem_memWrite) begin
      mem[mem_if.mem_address[9:0]]         <= mem_if.mem_writeData[31:24];
      mem[mem_if.mem_address[9:0] + 10'd1] <= mem_if.mem_writeData[23:16];
      mem[mem_if.mem_address[9:0] + 10'd2] <= mem_if.mem_writeData[15:8];
      mem[mem_if.mem_address[9:0] + 10'd3] <= mem_if.mem_writeData[7:0];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = (sz == 2'b11);
`ifdef MAU_ALIGN_CHECK_EN
    if (sz == 2'b01 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) e = 1'b1;
`else
    if (a > 32'hFFFF_FFFF) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int     nb;
    longint v;
    nb = size_bytes(sz);
    v  = 0;
    for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_mem[int'((a + 32'(i)) % 1024)]);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    nb = size_bytes(sz);
    for (int i = 0; i < nb; i++) ref_mem[int'((a + 32'(i)) % 1024)] = 8'(wd >> (8 * (nb - 1 - i)));
  endtask

  // Issue one request and watch it until resp_valid; cycle k is the one after accept edge T+k-1.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr, output int bad);
    rdata = '0; err = 1'b0; lat = -1; nrd = 0; nwr = 0; bad = 0;
    @(negedge clk);
    if (!req_if.req_ready) bad++;
    req_if.req_valid    = 1'b1;
    req_if.req_write    = wr;
    req_if.req_size     = sz;
    req_if.req_unsigned = uns;
    req_if.req_addr     = addr;
    req_if.req_wdata    = wd;
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_if.mem_memRead) nrd++;
      if (mem_if.mem_memWrite) nwr++;
      if (mem_if.mem_memRead && mem_if.mem_memWrite) bad++;
      if (!mem_if.mem_memWrite && mem_if.mem_writeData != 32'd0) bad++;
      if ((mem_if.mem_memRead || mem_if.mem_memWrite) && mem_if.mem_address != addr) bad++;
      if (req_if.req_ready) bad++;
      if (req_if.resp_valid) begin
        lat   = cyc;
        rdata = req_if.resp_rdata;
        err   = req_if.resp_err;
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_nrd, input int exp_nwr);
    logic [31:0] rd;
    logic        er;
    int          lat, nrd, nwr, bad;
    do_req(wr, sz, uns, addr, wd, rd, er, lat, nrd, nwr, bad);
    exp_q.push_back(exp_rd);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_rdata"},   rd, exp_q.pop_front());
    check({name, "_err"},     {31'd0, er}, {31'd0, exp_err});
    check({name, "_reads"},   32'(nrd), 32'(exp_nrd));
    check({name, "_writes"},  32'(nwr), 32'(exp_nwr));
    check({name, "_protocol"}, 32'(bad), 32'd0);
  endtask

  // Model-driven request: expectations come from the byte-level reference memory.
  task automatic model_req(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    logic        e;
    logic [31:0] exp_rd;
    int          exp_lat, exp_nrd, exp_nwr;
    e       = ref_err(sz, addr);
    exp_rd  = (e || wr) ? 32'd0 : ref_load(addr, sz, uns);
    exp_lat = e ? 1 : (wr && sz != 2'b10) ? 3 : 2;
    exp_nrd = (e || (wr && sz == 2'b10)) ? 0 : 1;
    exp_nwr = (!e && wr) ? 1 : 0;
    run_check(name, wr, sz, uns, addr, wd, exp_rd, e, exp_lat, exp_nrd, exp_nwr);
    if (wr && !e) ref_store(addr, sz, wd);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    req_if.req_valid    = 1'b0;
    req_if.req_write    = 1'b0;
    req_if.req_size     = 2'b00;
    req_if.req_unsigned = 1'b0;
    req_if.req_addr     = '0;
    req_if.req_wdata    = '0;

    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h100, 32'h0,        32'h00000080, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h00003456, 1'b0, 2, 1, 0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'hFFFF8012, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'h00008012, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 32'h0,        1'b0, 3, 1, 1};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h80AB3456, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1};
    vecs[8]  = '{1'b0, 2'b10, 1'b1, 32'h200, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
`ifdef MAU_ALIGN_CHECK_EN
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0};
`else
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h34560000, 1'b0, 2, 1, 0};
`endif
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_if.req_ready},     32'd1);
    check("rst_resp_valid", {31'd0, req_if.resp_valid},    32'd0);
    check("rst_resp_rdata", req_if.resp_rdata,             32'd0);
    check("rst_resp_err",   {31'd0, req_if.resp_err},      32'd0);
    check("rst_mem_addr",   mem_if.mem_address,            32'd0);
    check("rst_mem_wdata",  mem_if.mem_writeData,          32'd0);
    check("rst_mem_read",   {31'd0, mem_if.mem_memRead},   32'd0);
    check("rst_mem_write",  {31'd0, mem_if.mem_memWrite},  32'd0);
    idle_dbg = dbg_state;

    for (int i = 0; i < 11; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat,
                vecs[i].exp_nrd, vecs[i].exp_nwr);
      if (vecs[i].wr && !vecs[i].exp_err) ref_store(vecs[i].addr, vecs[i].sz, vecs[i].wd);
    end

    // Reset lands while the word store sits in ST_WR.
    @(negedge clk);
    req_if.req_valid = 1'b1;
    req_if.req_write = 1'b1;
    req_if.req_size  = 2'b10;
    req_if.req_addr  = 32'h300;
    req_if.req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_strobe_before", {31'd0, mem_if.mem_memWrite}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstwr_resp_valid", {31'd0, req_if.resp_valid}, 32'd0);
    check("rstwr_req_ready",  {31'd0, req_if.req_ready},  32'd1);
    check("rstwr_dbg_idle",   {29'd0, dbg_state},         {29'd0, idle_dbg});
    rst = 1'b0;
    @(negedge clk);
    check("rstwr_no_late_resp", {31'd0, req_if.resp_valid}, 32'd0);
    check("rstwr_mem_300", {mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]}, 32'd0);
    model_req("after_rst_lw", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    model_req("after_rst_sh", 1'b1, 2'b01, 1'b0, 32'h306, 32'h0000CAFE);
    model_req("after_rst_lh", 1'b0, 2'b01, 1'b1, 32'h306, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [1:0]  sz;
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      model_req($sformatf("rand%0d", i), wr, sz, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("final_mem_image", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store engine driving the byte-addressed, big-endian data memory port (address, writeData, readData, memWrite, memRead) of the pipeline.
- Accepts one request at a time from the MEM stage via a valid/ready handshake, issues memory strobes, and returns sign/zero-extended load data.
- Implements byte and halfword stores as read-modify-write, because the memory only writes whole 4-byte words.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  request rejected, valid with resp_valid
- mem_address  out  32  to memory address
- mem_writeData  out  32  to memory writeData
- mem_readData  in  32  from memory readData (combinational)
- mem_memWrite  out  1  memory write strobe
- mem_memRead  out  1  memory read strobe

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE. All outputs are 0 except req_ready = 1.
- Memory convention: big-endian. The byte at A maps to mem_readData[31:24].
  - Byte lane is [31:24]; halfword lane is [31:16].
  - mem_address is the latched req_addr, unmodified, and is 0 in IDLE.
- Handshake: a request is accepted on an edge where req_valid && req_ready. The request is latched.
  - req_ready = 1 only in IDLE.
  - resp_valid is a single-cycle pulse with no backpressure.
- FSM states: IDLE, LOAD, ST_RD, ST_WR, RESP.
  - IDLE to LOAD: accepted load.
  - IDLE to ST_WR: accepted word store.
  - IDLE to ST_RD: accepted byte or half store.
  - IDLE to RESP with resp_err = 1: accepted error request (reserved size, or misaligned under the optional feature). No strobes are issued.
  - LOAD: mem_memRead = 1. The extended data is captured at the end of the cycle. Next state RESP.
  - ST_RD: mem_memRead = 1. The old word is captured. Next state ST_WR.
  - ST_WR: mem_memWrite = 1. mem_writeData is either the word, or the old word with lane [31:24] (byte) or [31:16] (half) replaced by req_wdata[7:0] or [15:0]. Next state RESP.
  - RESP: resp_valid = 1. Next state IDLE.
- Latency, with accept at edge T:
  - Load: resp_valid in cycle T+2.
  - Word store: resp_valid in cycle T+2.
  - Sub-word store: resp_valid in cycle T+3.
  - Error: resp_valid in cycle T+1.
- Load extension:
  - Byte: the sign is bit 31 of mem_readData.
  - Half: the sign is bit 31 of mem_readData.
  - Word: passed through; req_unsigned is ignored.
- Strobes: mem_memRead and mem_memWrite are never asserted together. Neither is asserted outside LOAD, ST_RD or ST_WR.
- mem_writeData is 0 except in ST_WR.
- Reset mid-operation: mem_memWrite is gated by !rst, so no memory write commits on an edge where rst = 1. Any in-flight request is dropped with no response. The unit is in IDLE the next cycle.
- Requests presented while busy are ignored, because req_ready = 0. The requester holds them.
- Address wrap: the unit does no range check. Out-of-range handling belongs to the memory.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined: a half request with addr[0] != 0, or a word request with addr[1:0] != 0, is rejected. The unit goes IDLE to RESP with resp_err = 1 and issues no memory strobes.
- Undefined: misaligned accesses proceed normally, since the memory is byte-addressed. resp_err is asserted only for size 11.

Test Plan:
- Preload bytes 0x100..0x103 = 80 12 34 56. LB 0x100 signed gives resp_rdata 0xFFFFFF80 at T+2. LBU gives 0x00000080. One mem_memRead cycle each.
- LH 0x102 signed gives 0x00003456. LH 0x100 signed gives 0xFFFF8012.
- SB 0x101, wdata 0x000000AB. Expect ST_RD then ST_WR (one mem_memWrite cycle) and resp_valid at T+3. A following LW 0x100 returns 0x80AB3456.
- SW 0x200, wdata 0xDEADBEEF. Expect mem_memWrite high for exactly cycle T+1 and resp_valid at T+2. LW 0x200 returns 0xDEADBEEF.
- LW 0x102, with 0x104..0x105 = 0.
  - MAU_ALIGN_CHECK_EN defined: resp_err = 1 at T+1, no strobes.
  - Undefined: resp_rdata = 0x34560000.
  - Size 11: resp_err = 1 in both builds.
- SW 0x300, wdata 0x11223344, with rst = 1 during ST_WR. No write occurs and 0x300 stays 0. No resp_valid. req_ready = 1 the next cycle, and a new request is accepted normally.
